// File: rtl/mipi_rffe_master.sv
// MIPI RFFE register read/write master: SSC, command frame, data frame, bus park.
// Define MIPI_RFFE_PARITY_CHECK_EN to flag odd-parity errors on read data.
module mipi_rffe_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_vd,
    input  logic       cmd_rd,
    input  logic [3:0] cmd_sa,
    input  logic [4:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_err,
    output logic       sclk,
    output logic       sdo,
    output logic       sdo_en,
    input  logic       sdi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SSC,
        S_CMD,
        S_WDATA,
        S_RPARK,
        S_RDATA,
        S_PARK
    } state_t;

    localparam logic [8:0] HALF = 9'(CLK_DIV);
    localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

    state_t     state_q, state_d, state_nxt;
    logic [3:0] bit_q, bit_d, bit_last;
    logic [8:0] cnt_q, cnt_d;
    logic       last_cyc;

    logic       rd_q;
    logic [3:0] sa_q;
    logic [4:0] addr_q;
    logic [7:0] wd_q;
    logic [7:0] rx_q;
    logic [7:0] rd_data_q;
    logic       busy_q, done_q;
    logic       sclk_q, sdo_q, sdo_en_q;
    logic       sclk_d, sdo_d, sdo_en_d;

    logic [11:0] frame;
    logic        cmd_par, wd_par;

    assign frame    = {sa_q, 2'b01, rd_q, addr_q};
    assign cmd_par  = ~^frame;
    assign wd_par   = ~^wd_q;
    assign last_cyc = (cnt_q == LAST);

    always_comb begin
        bit_last  = 4'd0;
        state_nxt = S_IDLE;
        unique case (state_q)
            S_SSC: begin
                bit_last  = 4'd1;
                state_nxt = S_CMD;
            end
            S_CMD: begin
                bit_last  = 4'd12;
                state_nxt = rd_q ? S_RPARK : S_WDATA;
            end
            S_WDATA: begin
                bit_last  = 4'd8;
                state_nxt = S_PARK;
            end
            S_RPARK: begin
                bit_last  = 4'd0;
                state_nxt = S_RDATA;
            end
            S_RDATA: begin
                bit_last  = 4'd8;
                state_nxt = S_PARK;
            end
            default: begin
                bit_last  = 4'd0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Position (state, slot, cycle) for the next clock; outputs are derived from it.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = last_cyc ? 9'd0 : cnt_q + 9'd1;
        if (state_q == S_IDLE) begin
            cnt_d = 9'd0;
            bit_d = 4'd0;
            if (cmd_vd) begin
                state_d = S_SSC;
            end
        end else if (last_cyc) begin
            if (bit_q == bit_last) begin
                bit_d   = 4'd0;
                state_d = state_nxt;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end
    end

    always_comb begin
        sdo_d    = 1'b0;
        sdo_en_d = 1'b0;
        unique case (state_d)
            S_SSC: begin
                sdo_d    = (bit_d == 4'd0);
                sdo_en_d = 1'b1;
            end
            S_CMD: begin
                sdo_d    = (bit_d < 4'd12) ? frame[4'd11 - bit_d] : cmd_par;
                sdo_en_d = 1'b1;
            end
            S_WDATA: begin
                sdo_d    = (bit_d < 4'd8) ? wd_q[3'(4'd7 - bit_d)] : wd_par;
                sdo_en_d = 1'b1;
            end
            S_RPARK: begin
                // Release the line for the turnaround once sclk goes high.
                sdo_en_d = (cnt_d < HALF);
            end
            S_PARK: begin
                sdo_en_d = ~rd_q;
            end
            default: begin
                sdo_d    = 1'b0;
                sdo_en_d = 1'b0;
            end
        endcase
        sclk_d = (state_d != S_IDLE) && (state_d != S_SSC) && (cnt_d >= HALF);
    end

`ifdef MIPI_RFFE_PARITY_CHECK_EN
    logic par_q;
    logic rd_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_q     <= 4'd0;
            cnt_q     <= 9'd0;
            rd_q      <= 1'b0;
            sa_q      <= 4'd0;
            addr_q    <= 5'd0;
            wd_q      <= 8'd0;
            rx_q      <= 8'd0;
            rd_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            sdo_en_q  <= 1'b0;
`ifdef MIPI_RFFE_PARITY_CHECK_EN
            par_q     <= 1'b0;
            rd_err_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_q == S_PARK) && last_cyc;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
            sdo_en_q <= sdo_en_d;
            if (state_q == S_IDLE && cmd_vd) begin
                rd_q   <= cmd_rd;
                sa_q   <= cmd_sa;
                addr_q <= cmd_addr;
                wd_q   <= cmd_wdata;
            end
            if (state_q == S_RDATA && last_cyc) begin
                if (bit_q < 4'd8) begin
                    rx_q <= {rx_q[6:0], sdi};
                end
`ifdef MIPI_RFFE_PARITY_CHECK_EN
                if (bit_q == 4'd8) begin
                    par_q <= sdi;
                end
`endif
            end
            if (state_q == S_PARK && last_cyc) begin
                if (rd_q) begin
                    rd_data_q <= rx_q;
                end
`ifdef MIPI_RFFE_PARITY_CHECK_EN
                rd_err_q <= rd_q & ~(^{rx_q, par_q});
`endif
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign sclk    = sclk_q;
    assign sdo     = sdo_q;
    assign sdo_en  = sdo_en_q;
`ifdef MIPI_RFFE_PARITY_CHECK_EN
    assign rd_err  = rd_err_q;
`else
    assign rd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_rffe_master.sv
// Directed bench for mipi_rffe_master: write, read, parity, busy, reset, back-to-back.
module tb_mipi_rffe_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cmd_vd = 1'b0;
    logic       cmd_vd1 = 1'b0;
    logic       cmd_rd = 1'b0;
    logic [3:0] cmd_sa = 4'd0;
    logic [4:0] cmd_addr = 5'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       sdi = 1'b0;

    logic       busy, done, rd_err, sclk, sdo, sdo_en;
    logic [7:0] rd_data;
    logic       busy1, done1, rd_err1, sclk1, sdo1, sdo_en1;
    logic [7:0] rd_data1;

    mipi_rffe_master #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .cmd_vd(cmd_vd), .cmd_rd(cmd_rd),
        .cmd_sa(cmd_sa), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_err(rd_err),
        .sclk(sclk), .sdo(sdo), .sdo_en(sdo_en), .sdi(sdi)
    );

    mipi_rffe_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_vd(cmd_vd1), .cmd_rd(cmd_rd),
        .cmd_sa(cmd_sa), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .busy(busy1), .done(done1), .rd_data(rd_data1), .rd_err(rd_err1),
        .sclk(sclk1), .sdo(sdo1), .sdo_en(sdo_en1), .sdi(sdi)
    );

`ifdef MIPI_RFFE_PARITY_CHECK_EN
    localparam logic PERR = 1'b1;
`else
    localparam logic PERR = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    int busy_n, done_n, sdo_chg, sclk_bad;
    logic done_busy, post_ok;
    logic [7:0] rdd;
    logic rde;
    logic sdo_s [0:31];
    logic en0_s [0:31];
    logic en3_s [0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command on the CLK_DIV=2 instance and watch 112 cycles.
    task automatic run(input logic rd, input logic [3:0] sa, input logic [4:0] a,
                       input logic [7:0] wd, input logic [8:0] rx,
                       input int dup_c, input int abort_c);
        int slot, ph;
        busy_n = 0; done_n = 0; sdo_chg = 0; sclk_bad = 0;
        done_busy = 1'b0; post_ok = 1'b0; rdd = 8'hxx; rde = 1'bx;
        for (int s = 0; s < 32; s++) begin
            sdo_s[s] = 1'bx; en0_s[s] = 1'bx; en3_s[s] = 1'bx;
        end
        @(negedge clk);
        cmd_rd = rd; cmd_sa = sa; cmd_addr = a; cmd_wdata = wd; cmd_vd = 1'b1;
        for (int c = 0; c < 112; c++) begin
            @(negedge clk);
            if (c == 0) cmd_vd = 1'b0;
            slot = c / 4;
            ph = c % 4;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_busy = done_busy | busy;
                rdd = rd_data;
                rde = rd_err;
            end
            if (busy && slot < 32) begin
                if (ph == 0) begin
                    sdo_s[slot] = sdo;
                    en0_s[slot] = sdo_en;
                end else if (sdo !== sdo_s[slot]) begin
                    sdo_chg++;
                end
                if (ph == 3) en3_s[slot] = sdo_en;
                if (sclk !== ((slot >= 2) && (ph >= 2))) sclk_bad++;
            end
            if (rd && ph == 0 && slot >= 16 && slot <= 24) sdi = rx[24 - slot];
            if (c == dup_c) begin
                cmd_vd = 1'b1; cmd_rd = 1'b1; cmd_sa = 4'h3; cmd_addr = 5'h01;
            end
            if (c == dup_c + 1) cmd_vd = 1'b0;
            if (c == abort_c + 1) begin
                post_ok = !busy && !sclk && !sdo_en && !done;
                rst = 1'b0;
            end
            if (c == abort_c) rst = 1'b1;
        end
        sdi = 1'b0;
    endtask

    task automatic stream(input string tag, input int n, input logic [31:0] e_sdo,
                          input logic [31:0] e_en0, input logic [31:0] e_en3);
        logic [31:0] o_sdo, o_en0, o_en3;
        o_sdo = 32'd0; o_en0 = 32'd0; o_en3 = 32'd0;
        for (int s = 0; s < n; s++) begin
            o_sdo = {o_sdo[30:0], sdo_s[s]};
            o_en0 = {o_en0[30:0], en0_s[s]};
            o_en3 = {o_en3[30:0], en3_s[s]};
        end
        chk({tag, "_sdo"}, o_sdo, e_sdo);
        chk({tag, "_en_start"}, o_en0, e_en0);
        chk({tag, "_en_end"}, o_en3, e_en3);
        chk({tag, "_sdo_midslot"}, sdo_chg, 0);
        chk({tag, "_sclk"}, sclk_bad, 0);
    endtask

    logic [31:0] w_sdo, w_en, r_sdo, r_en0, r_en3;
    logic got;
    int bc;

    initial begin
        w_sdo = 32'b1011100101110000011100000;
        w_en  = 32'h01FF_FFFF;
        r_sdo = 32'b10010101100010000000000000;
        r_en0 = 32'h03FF_FC00;
        r_en3 = 32'h03FF_F800;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_sdo_en", sdo_en, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;

        @(negedge clk);
        rst = 1'b1; cmd_vd = 1'b1;
        @(negedge clk);
        chk("rst_with_cmd", busy, 0);
        rst = 1'b0; cmd_vd = 1'b0;
        @(negedge clk);
        chk("rst_with_cmd_after", busy, 0);

        run(1'b0, 4'hE, 5'h1C, 8'h38, 9'h000, -10, -10);
        stream("wr", 25, w_sdo, w_en, w_en);
        chk("wr_busy_cycles", busy_n, 100);
        chk("wr_done_count", done_n, 1);
        chk("wr_busy_at_done", done_busy, 0);
        chk("wr_rd_err", rde, 0);

        run(1'b1, 4'h5, 5'h02, 8'h00, 9'b101001011, -10, -10);
        stream("rd", 26, r_sdo, r_en0, r_en3);
        chk("rd_busy_cycles", busy_n, 104);
        chk("rd_done_count", done_n, 1);
        chk("rd_data", rdd, 8'hA5);
        chk("rd_err", rde, 0);

        run(1'b1, 4'h5, 5'h02, 8'h00, 9'b101001010, -10, -10);
        chk("badpar_rd_data", rdd, 8'hA5);
        chk("badpar_rd_err", rde, PERR);
        chk("badpar_done_count", done_n, 1);

        run(1'b0, 4'hE, 5'h1C, 8'h38, 9'h000, 29, -10);
        stream("dup", 25, w_sdo, w_en, w_en);
        chk("dup_done_count", done_n, 1);
        chk("dup_busy_cycles", busy_n, 100);
        chk("wr_keeps_rd_data", rdd, 8'hA5);
        chk("wr_clears_rd_err", rde, 0);

        run(1'b0, 4'hE, 5'h1C, 8'h38, 9'h000, -10, 73);
        chk("abort_outputs_idle", post_ok, 1);
        chk("abort_no_done", done_n, 0);

        run(1'b0, 4'hE, 5'h1C, 8'h38, 9'h000, -10, -10);
        stream("fresh", 25, w_sdo, w_en, w_en);
        chk("fresh_busy_cycles", busy_n, 100);
        chk("fresh_done_count", done_n, 1);

        cmd_rd = 1'b0; cmd_sa = 4'hE; cmd_addr = 5'h1C; cmd_wdata = 8'h38;
        @(negedge clk);
        cmd_vd1 = 1'b1;
        @(negedge clk);
        cmd_vd1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
        end
        chk("b2b_first_done", got, 1);
        chk("b2b_busy_at_done", busy1, 0);
        cmd_vd1 = 1'b1;
        @(negedge clk);
        cmd_vd1 = 1'b0;
        chk("b2b_busy_next", busy1, 1);
        chk("b2b_ssc0_sdo", sdo1, 1);
        chk("b2b_ssc0_en", sdo_en1, 1);
        chk("b2b_ssc0_sclk", sclk1, 0);
        @(negedge clk);
        chk("b2b_ssc0_sclk_hi_half", sclk1, 0);
        @(negedge clk);
        chk("b2b_ssc1_sdo", sdo1, 0);
        bc = 3;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
            else if (busy1) bc++;
        end
        chk("b2b_second_done", got, 1);
        chk("b2b_busy_cycles", bc, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
